// File: rtl/csdf_rr_scheduler_pkg.sv
// Shared types, default sizing and the round-robin pick function for csdf_rr_scheduler.
package csdf_sched_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int N_CH_DEF   = 4;
    localparam int PHASES_DEF = 4;
    localparam int CH_W       = $clog2(N_CH_DEF);
    localparam int TOK_W      = $clog2(PHASES_DEF + 2);

    // rr_pick works on a fixed 32-lane vector so it can serve any N_CH up to 31.
    localparam int MAX_CH = 32;
    localparam int MAX_W  = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // First requester found scanning last+1, last+2, ... (mod n); one-hot result.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                  input int last,
                                                  input int n);
        logic [MAX_CH-1:0] pick;
        logic [MAX_W-1:0]  idx;
        pick = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = MAX_W'((last + k) % n);
            if (k <= n && pick == '0 && req[idx]) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/csdf_rr_scheduler_if.sv
// FIFO-side and actor-side signal bundle of csdf_rr_scheduler.
// Handshake: FIFO-style empty/rd and full/wr pairs; a strobe only transfers a token
// in a cycle where the matching empty (or full) flag is low, and strobes are single-cycle.
interface csdf_rr_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4
);
    logic [N_CH-1:0]       in_empty;
    logic [N_CH-1:0]       in_rd;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       out_full;
    logic [N_CH-1:0]       out_wr;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [WIDTH-1:0]      act_in_data;
    logic                  act_in_empty;
    logic                  act_in_rd;
    logic [WIDTH-1:0]      act_out_data;
    logic                  act_out_wr;
    logic                  act_out_full;

    modport slave (
        input  in_empty, in_data, out_full, act_in_rd, act_out_data, act_out_wr,
        output in_rd, out_wr, out_data, act_in_data, act_in_empty, act_out_full
    );

    modport master (
        output in_empty, in_data, out_full, act_in_rd, act_out_data, act_out_wr,
        input  in_rd, out_wr, out_data, act_in_data, act_in_empty, act_out_full
    );
endinterface

// File: rtl/csdf_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus last owner index -> one-hot winner.
module rr_arbiter
    import csdf_sched_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int LAST_W = 2
) (
    input  logic [N_CH-1:0]   req,
    input  logic [LAST_W-1:0] last,
    output logic [N_CH-1:0]   gnt
);

    logic [MAX_CH-1:0] req_full;
    logic [MAX_CH-1:0] gnt_full;
    logic              unused_hi;

    always_comb begin
        req_full           = '0;
        req_full[N_CH-1:0] = req;
        gnt_full           = rr_pick(req_full, int'(last), N_CH);
    end

    assign gnt       = gnt_full[N_CH-1:0];
    assign unused_hi = ^gnt_full[MAX_CH-1:N_CH];

endmodule

// File: rtl/csdf_rr_scheduler.sv
// Shares one PHASES-read/one-write CSDF actor among N_CH FIFO channel pairs, round-robin per firing.
// Optional protocol checker driving err: define CSDF_SCHED_CHECK_EN.
module csdf_rr_scheduler
    import csdf_sched_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int PHASES = PHASES_DEF
) (
    input  logic               ck,
    input  logic               rst,
    csdf_rr_scheduler_if.slave bus,
    output logic [N_CH-1:0]    grant,
    output logic               err,
    output state_t             dbg_state
);

    // Package widths describe the default build; other sizes derive their own.
    localparam int IDX_W = (N_CH == N_CH_DEF) ? CH_W : $clog2(N_CH);
    localparam int CNT_W = (PHASES == PHASES_DEF) ? TOK_W : $clog2(PHASES + 2);
    localparam logic [CNT_W-1:0] TOK_MAX = CNT_W'(PHASES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] tok_cnt;
    logic [N_CH-1:0]  win;
    logic             tok_rd;
    logic             rel;

    rr_arbiter #(.N_CH(N_CH), .LAST_W(IDX_W)) u_arb (
        .req  (~bus.in_empty),
        .last (last),
        .gnt  (win)
    );

    always_comb begin
        owner = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant[c]) owner = IDX_W'(c);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|win) state_nxt = S_BUSY;
            S_BUSY:  if (rel)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outside BUSY the actor sees an empty input and a full output, so it is frozen.
    always_comb begin
        bus.in_rd        = '0;
        bus.out_wr       = '0;
        bus.act_in_empty = 1'b1;
        bus.act_out_full = 1'b1;
        bus.act_in_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (state == S_BUSY && grant[c]) begin
                bus.act_in_empty = bus.in_empty[c];
                bus.act_in_data  = bus.in_data[c*WIDTH +: WIDTH];
                bus.act_out_full = bus.out_full[c];
                bus.in_rd[c]     = bus.act_in_rd & ~bus.in_empty[c];
                bus.out_wr[c]    = bus.act_out_wr & ~bus.out_full[c];
            end
        end
    end

    assign bus.out_data = {N_CH{bus.act_out_data}};
    assign tok_rd       = |bus.in_rd;
    assign rel          = |bus.out_wr;
    assign dbg_state    = state;

    // The owner keeps the actor until its output token is accepted downstream.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            grant   <= '0;
            last    <= IDX_W'(N_CH - 1);
            tok_cnt <= '0;
        end else begin
            if (state == S_IDLE) grant <= win;
            else if (rel)        grant <= '0;
            if (rel) last <= owner;
            if (rel)                               tok_cnt <= '0;
            else if (tok_rd && tok_cnt != TOK_MAX) tok_cnt <= tok_cnt + CNT_W'(1);
        end
    end

`ifdef CSDF_SCHED_CHECK_EN
    localparam logic [CNT_W-1:0] TOK_LIM = CNT_W'(PHASES);
    logic err_q;
    logic err_set;

    // Actor activity while frozen, or a read beyond PHASES in one firing.
    always_comb begin
        err_set = (state == S_IDLE && (bus.act_out_wr || bus.act_in_rd)) ||
                  (tok_rd && tok_cnt >= TOK_LIM);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | err_set;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_csdf_rr_scheduler.sv
// Self-checking bench for csdf_rr_scheduler: FIFO queues, an accumulator actor and a firing-level model.
module tb_csdf_rr_scheduler;
    import csdf_sched_pkg::*;

    localparam int WIDTH  = 32;
    localparam int N_CH   = 4;
    localparam int PHASES = 4;
`ifdef CSDF_SCHED_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic            ck;
    logic            rst;
    logic [N_CH-1:0] grant;
    logic            err;
    state_t          dbg_state;

    csdf_rr_scheduler_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

    csdf_rr_scheduler #(.WIDTH(WIDTH), .N_CH(N_CH), .PHASES(PHASES)) dut (
        .ck        (ck),
        .rst       (rst),
        .bus       (bus.slave),
        .grant     (grant),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // environment and reference state
    logic [WIDTH-1:0] fifo_q[N_CH][$];
    logic [WIDTH-1:0] exp_q[N_CH][$];
    int               push_cnt[N_CH];
    logic [WIDTH-1:0] push_sum[N_CH];
    int               fire_q[$];
    logic [WIDTH-1:0] last_out;
    logic [N_CH-1:0]  bp_force;
    bit               rand_bp, act_stall, force_rd, exp_err;
    int               act_cnt;
    logic [WIDTH-1:0] act_acc;
    bit               act_have;
    int               m_owner, m_last;
    int               n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int fire_at(input int i);
        if (i < fire_q.size()) return fire_q[i];
        return -1;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < N_CH; c++) n += exp_q[c].size();
        return n;
    endfunction

    task automatic clear_env();
        for (int c = 0; c < N_CH; c++) begin
            fifo_q[c].delete();
            exp_q[c].delete();
            push_cnt[c] = 0;
            push_sum[c] = '0;
        end
        fire_q.delete();
        last_out  = '0;
        act_cnt   = 0;
        act_acc   = '0;
        act_have  = 1'b0;
        m_owner   = -1;
        m_last    = N_CH - 1;
        bp_force  = '0;
        rand_bp   = 1'b0;
        act_stall = 1'b0;
        force_rd  = 1'b0;
        exp_err   = 1'b0;
        bus.act_in_rd    = 1'b0;
        bus.act_out_wr   = 1'b0;
        bus.act_out_data = '0;
        bus.in_empty     = '1;
        bus.in_data      = '0;
        bus.out_full     = '0;
    endtask

    // driver tasks
    task automatic push_tok(input int c, input logic [WIDTH-1:0] v);
        fifo_q[c].push_back(v);
        push_sum[c] = push_sum[c] + v;
        push_cnt[c]++;
        if (push_cnt[c] == PHASES) begin
            exp_q[c].push_back(push_sum[c]);
            push_cnt[c] = 0;
            push_sum[c] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_env();
        @(negedge ck);
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_in_rd", 32'(bus.in_rd), 32'd0);
        check_eq("rst_out_wr", 32'(bus.out_wr), 32'd0);
        check_eq("rst_act_in_empty", 32'(bus.act_in_empty), 32'd1);
        check_eq("rst_act_out_full", 32'(bus.act_out_full), 32'd1);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_state", 32'(dbg_state == S_BUSY), 32'd0);
        rst = 1'b0;
    endtask

    // One clock: drive FIFO flags, let the actor respond, compare, then commit at posedge.
    task automatic step();
        logic [N_CH-1:0]  exp_grant, exp_rd, exp_wr, rd_s, empty_s;
        logic             a_rd, a_wr, a_empty, a_full, exp_empty, exp_full;
        logic [WIDTH-1:0] a_data;
        int               idx;
        @(negedge ck);
        for (int c = 0; c < N_CH; c++) begin
            bus.in_empty[c] = (fifo_q[c].size() == 0);
            bus.in_data[c*WIDTH +: WIDTH] = (fifo_q[c].size() != 0) ? fifo_q[c][0] : '0;
            bus.out_full[c] = bp_force[c] | (rand_bp && $urandom_range(0, 3) == 0);
        end
        #1;
        bus.act_in_rd    = force_rd |
                           (!act_have && !bus.act_in_empty && (!act_stall || $urandom_range(0, 2) != 0));
        bus.act_out_wr   = act_have && !bus.act_out_full;
        bus.act_out_data = act_acc;
        #1;
        exp_grant = '0;
        exp_rd    = '0;
        exp_wr    = '0;
        exp_empty = 1'b1;
        exp_full  = 1'b1;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_rd[m_owner]    = bus.act_in_rd && fifo_q[m_owner].size() != 0;
            exp_wr[m_owner]    = bus.act_out_wr && !bus.out_full[m_owner];
            exp_empty          = (fifo_q[m_owner].size() == 0);
            exp_full           = bus.out_full[m_owner];
        end
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("state", 32'(dbg_state == S_BUSY), 32'(m_owner >= 0));
        check_eq("in_rd", 32'(bus.in_rd), 32'(exp_rd));
        check_eq("out_wr", 32'(bus.out_wr), 32'(exp_wr));
        check_eq("act_in_empty", 32'(bus.act_in_empty), 32'(exp_empty));
        check_eq("act_out_full", 32'(bus.act_out_full), 32'(exp_full));
        check_eq("err", 32'(err), 32'(exp_err));
        if (m_owner >= 0 && fifo_q[m_owner].size() != 0)
            check_eq("act_in_data", bus.act_in_data, fifo_q[m_owner][0]);
        for (int c = 0; c < N_CH; c++) begin
            if (bus.out_wr[c]) begin
                fire_q.push_back(c);
                last_out = bus.out_data[c*WIDTH +: WIDTH];
                check_eq("sb_depth", 32'(exp_q[c].size() != 0), 32'd1);
                if (exp_q[c].size() != 0)
                    check_eq("out_data", bus.out_data[c*WIDTH +: WIDTH], exp_q[c].pop_front());
                check_eq("out_lane", bus.out_data[(N_CH-1)*WIDTH +: WIDTH], act_acc);
            end
        end
        rd_s    = bus.in_rd;
        empty_s = bus.in_empty;
        a_rd    = bus.act_in_rd;
        a_wr    = bus.act_out_wr;
        a_empty = bus.act_in_empty;
        a_full  = bus.act_out_full;
        a_data  = bus.act_in_data;
        @(posedge ck);
        for (int c = 0; c < N_CH; c++) begin
            if (rd_s[c] && fifo_q[c].size() != 0) fifo_q[c].delete(0);
        end
        if (a_wr && !a_full) begin
            act_have = 1'b0;
            act_acc  = '0;
            act_cnt  = 0;
        end else if (!act_have && a_rd && !a_empty) begin
            act_acc = act_acc + a_data;
            act_cnt++;
            if (act_cnt == PHASES) act_have = 1'b1;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= N_CH; k++) begin
                idx = (m_last + k) % N_CH;
                if (m_owner < 0 && !empty_s[idx]) m_owner = idx;
            end
        end else if (exp_wr[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic run_fires(input int n, input int budget);
        int cyc = 0;
        while (fire_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check_eq("fire_count", 32'(fire_q.size()), 32'(n));
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        clear_env();

        // single channel: 1+2+3+4 on ch1
        do_reset();
        for (int v = 1; v <= 4; v++) push_tok(1, WIDTH'(v));
        run_fires(1, 40);
        check_eq("single_ch", 32'(fire_at(0)), 32'd1);
        check_eq("single_sum", last_out, 32'd10);
        repeat (3) step();
        #1;
        check_eq("single_idle", 32'(grant), 32'd0);

        // contention: ch0 then ch2, no interleaving
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_tok(0, $urandom_range(0, 255));
            push_tok(2, $urandom_range(0, 255));
        end
        run_fires(2, 60);
        check_eq("contend_first", 32'(fire_at(0)), 32'd0);
        check_eq("contend_second", 32'(fire_at(1)), 32'd2);

        // starvation hold: ch0 runs dry mid-firing
        do_reset();
        push_tok(0, 32'd5);
        push_tok(0, 32'd6);
        for (int i = 0; i < 8; i++) push_tok(3, $urandom());
        repeat (20) step();
        #1;
        check_eq("starve_hold", 32'(grant), 32'b0001);
        push_tok(0, 32'd7);
        push_tok(0, 32'd8);
        run_fires(2, 60);
        check_eq("starve_first", 32'(fire_at(0)), 32'd0);
        check_eq("starve_sum", 32'(fire_at(1)), 32'd3);

        // backpressure on ch2
        do_reset();
        bp_force[2] = 1'b1;
        for (int i = 0; i < 4; i++) push_tok(2, $urandom());
        cyc = 0;
        while (!act_have && cyc < 30) begin
            step();
            cyc++;
        end
        check_eq("bp_ready", 32'(act_have), 32'd1);
        repeat (5) step();
        #1;
        check_eq("bp_hold", 32'(grant), 32'b0100);
        check_eq("bp_no_fire", 32'(fire_q.size()), 32'd0);
        bp_force[2] = 1'b0;
        run_fires(1, 20);
        check_eq("bp_release", 32'(fire_at(0)), 32'd2);

        // fairness: 16 firings rotate 0,1,2,3
        do_reset();
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < N_CH; c++) push_tok(c, $urandom());
        end
        run_fires(16, 400);
        for (int i = 0; i < 16; i++) check_eq("fair_order", 32'(fire_at(i)), 32'(i % N_CH));

        // asynchronous reset mid-BUSY, then actor reads while frozen
        do_reset();
        for (int i = 0; i < 4; i++) push_tok(0, $urandom());
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        check_eq("mid_rst_state", 32'(dbg_state == S_BUSY), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        check_eq("mid_rst_act_empty", 32'(bus.act_in_empty), 32'd1);
        clear_env();
        @(negedge ck);
        rst = 1'b0;
        force_rd = 1'b1;
        step();
        force_rd = 1'b0;
        exp_err  = CHECK_EN;
        repeat (4) step();

        // randomized traffic with random backpressure and actor stalls
        do_reset();
        rand_bp   = 1'b1;
        act_stall = 1'b1;
        repeat (600) begin
            if ($urandom_range(0, 2) == 0) push_tok(int'($urandom_range(0, N_CH - 1)), $urandom());
            step();
        end
        for (int c = 0; c < N_CH; c++) begin
            while (push_cnt[c] != 0) push_tok(c, $urandom());
        end
        rand_bp = 1'b0;
        cyc = 0;
        while (pending() > 0 && cyc < 2000) begin
            step();
            cyc++;
        end
        check_eq("rand_drain", 32'(pending()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
